// File: rtl/serial_op_controller.sv
// serial_op_controller
//   Sequences one bit-serial operation between two external WIDTH-bit shift
//   registers A and B. A level Execute request starts exactly WIDTH shift
//   cycles, during which the bit computed from A_out/B_out (selected by the
//   latched function code) is routed back into the register MSBs. It then
//   holds until Execute is released, so a held request runs only once.
//
// Ports
//   Clk               rising-edge clock
//   Reset             asynchronous, active-low reset
//   Execute           level request to run one operation (already synchronous)
//   LoadA, LoadB      level requests to parallel-load A / B (honoured in IDLE)
//   F[2:0]            bitwise function select (latched at start)
//   R[1:0]            result routing select (latched at start)
//   A_out, B_out      serial bits leaving A / B (their LSBs)
//   Ld_A, Ld_B        parallel-load strobes to A / B
//   Shift_En          common shift-right enable for A and B
//   A_In, B_In        serial bits entering the MSBs of A / B
//   Busy              high whenever not IDLE
//   Done              one-cycle pulse in the first HOLD cycle
module serial_op_controller #(
    parameter int unsigned WIDTH = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Execute,
    input  logic       LoadA,
    input  logic       LoadB,
    input  logic [2:0] F,
    input  logic [1:0] R,
    input  logic       A_out,
    input  logic       B_out,
    output logic       Ld_A,
    output logic       Ld_B,
    output logic       Shift_En,
    output logic       A_In,
    output logic       B_In,
    output logic       Busy,
    output logic       Done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        HOLD
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [2:0]      F_q;
    logic [1:0]      R_q;
    logic            first_hold;
    logic            fb;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            F_q        <= '0;
            R_q        <= '0;
            first_hold <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            // Marks the first HOLD cycle so Done pulses once however long HOLD lasts.
            first_hold <= (state == SHIFT) && (state_nxt == HOLD);
            if (state == IDLE && Execute) begin
                F_q <= F;
                R_q <= R;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        Ld_A      = 1'b0;
        Ld_B      = 1'b0;
        Shift_En  = 1'b0;
        case (state)
            IDLE: begin
                if (Execute) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                end else begin
                    // Gated by Reset: state already reads IDLE during reset.
                    Ld_A = Reset & LoadA;
                    Ld_B = Reset & LoadB;
                end
            end
            SHIFT: begin
                Shift_En = 1'b1;
                cnt_nxt  = cnt + CW'(1);
                if (cnt == LAST) begin
                    state_nxt = HOLD;
                    cnt_nxt   = '0;
                end
            end
            HOLD: begin
                if (!Execute) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign Busy = (state != IDLE);
    assign Done = (state == HOLD) && first_hold;

    always_comb begin
        case (F_q)
            3'b000:  fb = A_out & B_out;
            3'b001:  fb = A_out | B_out;
            3'b010:  fb = A_out ^ B_out;
            3'b011:  fb = 1'b1;
            3'b100:  fb = ~(A_out & B_out);
            3'b101:  fb = ~(A_out | B_out);
            3'b110:  fb = ~(A_out ^ B_out);
            default: fb = 1'b0;
        endcase
    end

    always_comb begin
        A_In = A_out;
        B_In = B_out;
        case (R_q)
            2'b01: A_In = fb;
            2'b10: B_In = fb;
            2'b11: begin
                A_In = B_out;
                B_In = A_out;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_op_controller.sv
module tb_serial_op_controller;

    localparam int W = 8;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         Execute = 1'b0;
    logic         LoadA = 1'b0;
    logic         LoadB = 1'b0;
    logic [2:0]   F = '0;
    logic [1:0]   R = '0;
    logic         A_out, B_out;
    logic         Ld_A, Ld_B, Shift_En, A_In, B_In, Busy, Done;

    logic [W-1:0] bus = '0;
    logic [W-1:0] reg_a = '0;
    logic [W-1:0] reg_b = '0;
    logic [W-1:0] mdl_a = '0;
    logic [W-1:0] mdl_b = '0;

    int total = 0;
    int bad = 0;

    always #5 Clk = ~Clk;

    serial_op_controller #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset(Reset), .Execute(Execute), .LoadA(LoadA), .LoadB(LoadB),
        .F(F), .R(R), .A_out(A_out), .B_out(B_out),
        .Ld_A(Ld_A), .Ld_B(Ld_B), .Shift_En(Shift_En), .A_In(A_In), .B_In(B_In),
        .Busy(Busy), .Done(Done)
    );

    // External shift registers driven by the controller.
    always @(posedge Clk) begin
        if (Ld_A) reg_a <= bus;
        else if (Shift_En) reg_a <= {A_In, reg_a[W-1:1]};
        if (Ld_B) reg_b <= bus;
        else if (Shift_En) reg_b <= {B_In, reg_b[W-1:1]};
    end
    assign A_out = reg_a[0];
    assign B_out = reg_b[0];

    function automatic logic [W-1:0] fn(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        case (f)
            3'd0: fn = a & b;
            3'd1: fn = a | b;
            3'd2: fn = a ^ b;
            3'd3: fn = '1;
            3'd4: fn = ~(a & b);
            3'd5: fn = ~(a | b);
            3'd6: fn = ~(a ^ b);
            default: fn = '0;
        endcase
    endfunction

    task automatic test_reset();
        Reset = 1'b0; Execute = 1'b1; LoadA = 1'b1; LoadB = 1'b1;
        repeat (2) @(negedge Clk);
        total++;
        if ({Ld_A, Ld_B, Shift_En, Busy, Done} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs: got {Ld_A,Ld_B,Shift_En,Busy,Done}=%b want 00000",
                     {Ld_A, Ld_B, Shift_En, Busy, Done});
        end
        Execute = 1'b0; LoadA = 1'b0; LoadB = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        total++;
        if (Busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release_idle: Busy=%b want 0", Busy);
        end
    endtask

    task automatic load_reg(input bit which_b, input logic [W-1:0] v);
        @(negedge Clk);
        bus = v;
        if (which_b) LoadB = 1'b1; else LoadA = 1'b1;
        #1;
        total++;
        if (Ld_A !== !which_b || Ld_B !== which_b) begin
            bad++;
            $display("FAIL load_strobe: Ld_A=%b Ld_B=%b want %b %b", Ld_A, Ld_B, !which_b, which_b);
        end
        @(negedge Clk);
        LoadA = 1'b0; LoadB = 1'b0;
        if (which_b) mdl_b = v; else mdl_a = v;
    endtask

    task automatic test_load_both(input logic [W-1:0] v);
        @(negedge Clk);
        bus = v; LoadA = 1'b1; LoadB = 1'b1;
        #1;
        total++;
        if (Ld_A !== 1'b1 || Ld_B !== 1'b1) begin
            bad++;
            $display("FAIL load_both_strobe: Ld_A=%b Ld_B=%b want 1 1", Ld_A, Ld_B);
        end
        @(negedge Clk);
        LoadA = 1'b0; LoadB = 1'b0;
        mdl_a = v; mdl_b = v;
        total++;
        if (reg_a !== v || reg_b !== v) begin
            bad++;
            $display("FAIL load_both_data: A=%h B=%h want %h %h", reg_a, reg_b, v, v);
        end
    endtask

    // One operation: Execute goes high before edge k, cycle c is the c-th cycle after it.
    task automatic run_op(input logic [2:0] f, input logic [1:0] r, input int exec_len,
                          input bit hold_load, input bit change_f, input string name);
        logic [W-1:0] fw, ea, eb;
        int busy_end;
        fw = fn(f, mdl_a, mdl_b);
        case (r)
            2'b00: begin ea = mdl_a; eb = mdl_b; end
            2'b01: begin ea = fw;    eb = mdl_b; end
            2'b10: begin ea = mdl_a; eb = fw;    end
            default: begin ea = mdl_b; eb = mdl_a; end
        endcase
        busy_end = (exec_len > W + 1) ? exec_len : W + 1;

        @(negedge Clk);
        F = f; R = r; Execute = 1'b1; LoadA = hold_load; LoadB = hold_load;
        #1;
        total++;
        if (Ld_A !== 1'b0 || Ld_B !== 1'b0 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_start: Ld_A=%b Ld_B=%b Busy=%b want 0 0 0", name, Ld_A, Ld_B, Busy);
        end
        for (int c = 1; c <= busy_end + 2; c++) begin
            @(negedge Clk);
            total++;
            if (Shift_En !== (c <= W) || Done !== (c == W + 1) || Busy !== (c <= busy_end)
                || Ld_A !== 1'b0 || Ld_B !== 1'b0) begin
                bad++;
                $display("FAIL %s_cycle%0d: Shift_En=%b Done=%b Busy=%b Ld=%b%b want %b %b %b 00",
                         name, c, Shift_En, Done, Busy, Ld_A, Ld_B,
                         (c <= W), (c == W + 1), (c <= busy_end));
            end
            if (c >= exec_len) Execute = 1'b0;
            if (c == busy_end) begin LoadA = 1'b0; LoadB = 1'b0; end
            if (change_f) F = 3'b001;
            else begin F = 3'($urandom); R = 2'($urandom); end
            bus = W'($urandom);
        end
        total++;
        if (reg_a !== ea || reg_b !== eb) begin
            bad++;
            $display("FAIL %s_result: A=%h B=%h want %h %h", name, reg_a, reg_b, ea, eb);
        end
        mdl_a = ea; mdl_b = eb;
    endtask

    task automatic test_basic();
        load_reg(0, 8'h33); load_reg(1, 8'h55);
        run_op(3'b000, 2'b01, 1, 0, 0, "and_to_a");
        total++;
        if (mdl_a !== 8'h11 || mdl_b !== 8'h55) begin
            bad++;
            $display("FAIL and_to_a_model: A=%h B=%h want 11 55", mdl_a, mdl_b);
        end
        load_reg(0, 8'h33); load_reg(1, 8'h55);
        run_op(3'b010, 2'b10, 1, 0, 0, "xor_to_b");
        run_op(3'b000, 2'b11, 1, 0, 0, "swap");
        total++;
        if (reg_a !== 8'h66 || reg_b !== 8'h33) begin
            bad++;
            $display("FAIL swap_value: A=%h B=%h want 66 33", reg_a, reg_b);
        end
    endtask

    task automatic test_held_execute();
        load_reg(0, 8'hA5); load_reg(1, 8'h3C);
        run_op(3'b110, 2'b00, 20, 0, 0, "held20");
    endtask

    task automatic test_load_ignored();
        load_reg(0, 8'h5A); load_reg(1, 8'hC3);
        run_op(3'b001, 2'b10, 12, 1, 0, "load_ignored");
    endtask

    task automatic test_latched_f();
        load_reg(0, 8'h0F); load_reg(1, 8'hF0);
        run_op(3'b000, 2'b01, 1, 0, 1, "latched_f");
        total++;
        if (reg_a !== 8'h00) begin
            bad++;
            $display("FAIL latched_f_value: A=%h want 00", reg_a);
        end
    endtask

    task automatic test_abort();
        load_reg(0, 8'h81); load_reg(1, 8'h7E);
        @(negedge Clk);
        F = 3'b010; R = 2'b01; Execute = 1'b1;
        repeat (3) @(negedge Clk);
        @(posedge Clk);
        #2;
        total++;
        if (Shift_En !== 1'b1 || Busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_in_shift: Shift_En=%b Busy=%b want 1 1", Shift_En, Busy);
        end
        Reset = 1'b0;
        #1;
        total++;
        if (Shift_En !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL abort_immediate: Shift_En=%b Busy=%b Done=%b want 0 0 0", Shift_En, Busy, Done);
        end
        Execute = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            total++;
            if (Shift_En !== 1'b0 || Busy !== 1'b0 || Done !== 1'b0) begin
                bad++;
                $display("FAIL abort_after%0d: Shift_En=%b Busy=%b Done=%b want 0 0 0",
                         c, Shift_En, Busy, Done);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++) begin
            load_reg(0, W'($urandom)); load_reg(1, W'($urandom));
            run_op(3'($urandom), 2'($urandom), int'($urandom_range(1, 15)),
                   1'($urandom), 0, "random");
        end
    endtask

    task automatic test_back_to_back();
        load_reg(0, 8'hC9); load_reg(1, 8'h1E);
        run_op(3'b100, 2'b01, 1, 0, 0, "b2b_1");
        run_op(3'b101, 2'b10, 1, 0, 0, "b2b_2");
        run_op(3'b011, 2'b01, 1, 0, 0, "b2b_3");
        run_op(3'b111, 2'b10, 1, 0, 0, "b2b_4");
    endtask

    initial begin
        test_reset();
        test_load_both(8'h96);
        test_basic();
        test_held_execute();
        test_load_ignored();
        test_latched_f();
        test_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
